nkmm_pmem_loader: RTL and testbench

Program-memory block feeding the nkmm CPU instruction-fetch stage. It owns the instruction RAM and serves the CPU's `prog_addr_o` with a one-cycle registered read. At boot it holds the CPU in reset while it receives a program image over a byte-stream valid/ready link (UART receiver or host bridge). It assembles little-endian words, writes them sequentially from address 0, verifies an XOR checksum, and then releases the CPU.

---
 rtl/nkmm_pmem_loader_if.sv | 19 +
 rtl/nkmm_pmem_loader.sv | 115 +++++++++++
 tb/tb_nkmm_pmem_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nkmm_pmem_loader_if.sv
// Byte-stream valid/ready link carrying the program image
// from a UART receiver or host bridge into the loader.
interface nkmm_pmem_loader_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;

    modport master (
        output rx_data_i,
        output rx_valid_i,
        input  rx_ready_o
    );

    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        output rx_ready_o
    );
endinterface

// File: rtl/nkmm_pmem_loader.sv
// Instruction RAM with boot-time image loader: holds the CPU
// in reset until a checksummed image has been written.
module nkmm_pmem_loader #(
    parameter int INSN_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    nkmm_pmem_loader_if.slave     rx,
    input  logic                  boot_i,
    input  logic [ADDR_WIDTH-1:0] prog_addr_i,
    output logic [INSN_WIDTH-1:0] prog_data_o,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  err_o
);

    localparam logic [2:0] S_HDR0 = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [7:0]            r_csum;
    logic [7:0]            r_count_lo;
    logic [15:0]           r_words_left;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [1:0]            r_idx;
    logic [INSN_WIDTH-1:0] r_word;
    logic [INSN_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    logic                  w_load;
    logic                  w_xfer;
    logic                  w_we;
    logic [15:0]           w_count;
    logic [INSN_WIDTH-1:0] w_wdata;

    assign w_load = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                    (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer  = rx.rx_valid_i && w_load && !rst && !boot_i;
    assign w_we    = w_xfer && (r_state == S_DATA) && (r_idx == 2'd3);
    assign w_count = {rx.rx_data_i, r_count_lo};
    assign w_wdata = {rx.rx_data_i, r_word[23:0]};

    assign rx.rx_ready_o = w_load;
    assign cpu_rst_o     = (r_state != S_RUN);
    assign load_done_o   = (r_state == S_RUN);
    assign err_o         = (r_state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst || boot_i) begin
            r_state      <= S_HDR0;
            r_csum       <= 8'd0;
            r_count_lo   <= 8'd0;
            r_words_left <= 16'd0;
            r_wr_addr    <= '0;
            r_idx        <= 2'd0;
            r_word       <= '0;
        end else if (w_xfer) begin
            unique case (r_state)
                S_HDR0: begin
                    r_count_lo <= rx.rx_data_i;
                    r_csum     <= rx.rx_data_i;
                    r_state    <= S_HDR1;
                end
                S_HDR1: begin
                    r_csum       <= r_csum ^ rx.rx_data_i;
                    r_words_left <= w_count;
                    r_wr_addr    <= '0;
                    r_idx        <= 2'd0;
                    if ({1'b0, w_count} > MAX_N)
                        r_state <= S_ERR;
                    else if (w_count == 16'd0)
                        r_state <= S_CSUM;
                    else
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    r_csum                <= r_csum ^ rx.rx_data_i;
                    r_word[8*r_idx +: 8]  <= rx.rx_data_i;
                    r_idx                 <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_idx        <= 2'd0;
                        r_wr_addr    <= r_wr_addr + 1'b1;
                        r_words_left <= r_words_left - 16'd1;
                        if (r_words_left == 16'd1)
                            r_state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    r_state <= (rx.rx_data_i == r_csum) ? S_RUN : S_ERR;
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately never cleared; only the read register resets.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_addr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            prog_data_o <= '0;
        else
            prog_data_o <= r_mem[prog_addr_i];
    end

endmodule

// File: tb/tb_nkmm_pmem_loader.sv
// Randomized image loads checked against an image-level model
// of expected RAM contents and final loader outcome.
module tb_nkmm_pmem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          boot_i = 1'b0;
    logic [AW-1:0] prog_addr_i = '0;
    logic [31:0]   prog_data_o;
    logic          cpu_rst_o;
    logic          load_done_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  img [$];
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    nkmm_pmem_loader_if bus ();

    nkmm_pmem_loader #(
        .INSN_WIDTH (32),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus.slave),
        .boot_i      (boot_i),
        .prog_addr_i (prog_addr_i),
        .prog_data_o (prog_data_o),
        .cpu_rst_o   (cpu_rst_o),
        .load_done_o (load_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int img_count();
        return int'(img[0]) | (int'(img[1]) << 8);
    endfunction

    function automatic logic [31:0] img_word(input int i);
        return {img[5+4*i], img[4+4*i], img[3+4*i], img[2+4*i]};
    endfunction

    // Image-level expectation: well-formed, fully delivered, XOR matches.
    function automatic bit img_good(input int sent);
        logic [7:0] x;
        int n;
        n = img_count();
        if (n > DEPTH || sent != img.size()) return 1'b0;
        if (img.size() != 2 + 4*n + 1) return 1'b0;
        x = 8'h00;
        for (int i = 0; i < img.size() - 1; i++) x ^= img[i];
        return x == img[img.size()-1];
    endfunction

    task automatic model_written(input int sent);
        int n, w;
        n = img_count();
        if (sent < 2 || n > DEPTH) return;
        w = (sent - 2) / 4;
        if (w > n) w = n;
        for (int i = 0; i < w; i++) begin
            ref_mem[i]   = img_word(i);
            ref_known[i] = 1'b1;
        end
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        img.delete();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
        end
        x = 8'h00;
        foreach (img[i]) x ^= img[i];
        if (bad) x ^= 8'(1 + $urandom_range(0, 254));
        img.push_back(x);
    endtask

    task automatic send(input int from, input int to,
                        input bit gaps, inout int sent);
        for (int i = from; i < to; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            if (!bus.rx_ready_o) break;
            bus.rx_data_i  = img[i];
            bus.rx_valid_i = 1'b1;
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            bus.rx_data_i  = 8'($urandom);
            sent++;
        end
    endtask

    task automatic check_outcome(input string tag, input bit good);
        check({tag, "_done"},  32'(load_done_o), 32'(good));
        check({tag, "_cpurst"}, 32'(cpu_rst_o),  32'(!good));
        check({tag, "_err"},   32'(err_o),       32'(!good));
        check({tag, "_ready"}, 32'(bus.rx_ready_o), 32'd0);
    endtask

    task automatic verify_mem(input string tag, input int lim);
        for (int a = 0; a < lim && a < DEPTH; a++) begin
            if (ref_known[a]) begin
                prog_addr_i = AW'(a);
                @(negedge clk);
                check(tag, prog_data_o, ref_mem[a]);
            end
        end
    endtask

    task automatic run_img(input string tag, input bit gaps);
        int sent;
        bit good;
        sent = 0;
        send(0, img.size() - 1, gaps, sent);
        check({tag, "_pre"}, 32'(cpu_rst_o), 32'd1);
        send(img.size() - 1, img.size(), gaps, sent);
        model_written(sent);
        good = img_good(sent);
        check_outcome(tag, good);
        verify_mem(tag, img_count() + 3);
    endtask

    task automatic do_boot();
        boot_i = 1'b1;
        @(negedge clk);
        boot_i = 1'b0;
    endtask

    initial begin
        int sent;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cpurst", 32'(cpu_rst_o), 32'd1);
        check("rst_ready", 32'(bus.rx_ready_o), 32'd1);
        check("rst_done", 32'(load_done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_pdata", prog_data_o, 32'd0);
        bus.rx_valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        img = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46};
        run_img("nominal", 1'b0);
        prog_addr_i = 10'd0;
        @(negedge clk);
        check("nom_w0", prog_data_o, 32'h11223344);
        prog_addr_i = 10'd1;
        @(negedge clk);
        check("nom_w1", prog_data_o, 32'hAABBCCDD);

        do_boot();
        check("bootrun_cpurst", 32'(cpu_rst_o), 32'd1);
        check("bootrun_ready", 32'(bus.rx_ready_o), 32'd1);

        img[10] = 8'h47;
        run_img("badcsum", 1'b0);

        do_boot();
        img = '{8'h01, 8'h04};
        sent = 0;
        send(0, 2, 1'b0, sent);
        check_outcome("oversize", 1'b0);

        do_boot();
        img = '{8'h00, 8'h00, 8'h00};
        run_img("empty", 1'b0);
        verify_mem("empty_ram", 4);

        for (int t = 0; t < 12; t++) begin
            do_boot();
            build($urandom_range(1, 20), ($urandom_range(0, 3) == 0));
            run_img("rand", 1'b1);
        end

        do_boot();
        build(4, 1'b0);
        sent = 0;
        send(0, 11, 1'b1, sent);
        model_written(sent);
        do_boot();
        check("abort_ready", 32'(bus.rx_ready_o), 32'd1);
        check("abort_cpurst", 32'(cpu_rst_o), 32'd1);
        verify_mem("abort_ram", 4);
        build(5, 1'b0);
        run_img("reload", 1'b1);

        do_boot();
        bus.rx_data_i  = 8'hFF;
        bus.rx_valid_i = 1'b1;
        boot_i = 1'b1;
        @(negedge clk);
        boot_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        build(3, 1'b0);
        run_img("bootxfer", 1'b0);

        do_boot();
        build(6, 1'b0);
        sent = 0;
        send(0, 14, 1'b0, sent);
        model_written(sent);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cpurst", 32'(cpu_rst_o), 32'd1);
        check("midrst_ready", 32'(bus.rx_ready_o), 32'd1);
        check("midrst_done", 32'(load_done_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        verify_mem("midrst_ram", 8);

        build(DEPTH, 1'b0);
        run_img("full", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
